// File: rtl/rx_tx_pkg.sv
// ============================================================================
// Module   : rx_tx_pkg
// Brief    : Shared RX/TX datapath constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rx_tx_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

`default_nettype wire

// File: rtl/switch_pkg.sv
// ============================================================================
// Module   : switch_pkg
// Brief    : Switch-core constants and the ingress arbiter state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package switch_pkg;
    localparam int NUM_PORTS     = 4;
    localparam int STALL_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Picks the first set request at or after a pointer, wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         i_req,
    input  logic [$clog2(NUM_PORTS)-1:0] i_ptr,
    output logic [NUM_PORTS-1:0]         o_gnt,
    output logic                         o_valid
);
    localparam int c_PW = $clog2(NUM_PORTS);

    logic [c_PW:0]   w_sum;
    logic [c_PW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Extra sum bit keeps the wrap correct for non-power-of-two port counts.
            w_sum = {1'b0, i_ptr} + (c_PW+1)'(i);
            if (w_sum >= (c_PW+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (c_PW+1)'(NUM_PORTS);
            end
            w_idx = w_sum[c_PW-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/rx_ingress_arbiter.sv
// ============================================================================
// Module   : rx_ingress_arbiter
// Brief    : Frame-granular round-robin merge of RX ports into one buffer stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_ingress_arbiter
    import switch_pkg::*;
#(
    parameter int NUM_PORTS     = switch_pkg::NUM_PORTS,
    parameter int DATA_WIDTH    = rx_tx_pkg::DATA_WIDTH,
    parameter int STALL_TIMEOUT = switch_pkg::STALL_TIMEOUT
) (
    input  logic                                 switch_clk,
    input  logic                                 switch_rst_n,
    input  logic [NUM_PORTS-1:0]                 rx_valid_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rx_data_i,
    input  logic [NUM_PORTS-1:0]                 rx_sof_i,
    input  logic [NUM_PORTS-1:0]                 rx_eof_i,
    input  logic [NUM_PORTS-1:0]                 rx_err_i,
    output logic [NUM_PORTS-1:0]                 rx_ready_o,
    output logic                                 mem_valid_o,
    output logic                                 mem_sof_o,
    output logic                                 mem_eof_o,
    output logic                                 mem_err_o,
    output logic [DATA_WIDTH-1:0]                mem_data_o,
    output logic [$clog2(NUM_PORTS)-1:0]         mem_port_o,
    input  logic                                 mem_ready_i,
    output logic [NUM_PORTS-1:0]                 drop_o
);
    localparam int c_PW      = $clog2(NUM_PORTS);
    localparam int c_STALL_W = $clog2(STALL_TIMEOUT + 1);

    arb_state_t           r_state;
    logic [c_PW-1:0]      r_grant;
    logic [c_PW-1:0]      r_rr_ptr;
    logic [c_STALL_W-1:0] r_stall;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_pick_oh;
    logic                 w_pick_valid;
    logic [c_PW-1:0]      w_pick_idx;
    logic [c_PW-1:0]      w_next_ptr;
    logic                 w_g_valid;
    logic                 w_g_eof;

    assign w_req      = rx_valid_i & rx_sof_i;
    assign w_g_valid  = rx_valid_i[r_grant];
    assign w_g_eof    = rx_eof_i[r_grant];
    assign w_next_ptr = (r_grant == c_PW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_oh),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pick_oh[p]) begin
                w_pick_idx = c_PW'(p);
            end
        end
    end

    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_stall  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_stall <= '0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_g_valid && mem_ready_i) begin
                        r_stall <= '0;
                        if (w_g_eof) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else if (!w_g_valid) begin
                        // A source starved for the full timeout gets its frame closed with an error beat.
                        if (r_stall == c_STALL_W'(STALL_TIMEOUT - 1)) begin
                            r_stall <= '0;
                            r_state <= ABORT;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    if (mem_ready_i) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready_o  = '0;
        drop_o      = '0;
        mem_valid_o = 1'b0;
        mem_sof_o   = 1'b0;
        mem_eof_o   = 1'b0;
        mem_err_o   = 1'b0;
        mem_data_o  = '0;
        mem_port_o  = '0;
        case (r_state)
            IDLE: begin
                // Beats without sof while idle belong to no frame and are flushed.
                if (switch_rst_n) begin
                    rx_ready_o = rx_valid_i & ~rx_sof_i;
                    drop_o     = rx_valid_i & ~rx_sof_i;
                end
            end
            XFER: begin
                mem_valid_o         = w_g_valid;
                mem_sof_o           = rx_sof_i[r_grant];
                mem_eof_o           = w_g_eof;
                mem_err_o           = rx_err_i[r_grant];
                mem_data_o          = rx_data_i[r_grant];
                mem_port_o          = r_grant;
                rx_ready_o[r_grant] = mem_ready_i;
            end
            ABORT: begin
                mem_valid_o = 1'b1;
                mem_eof_o   = 1'b1;
                mem_err_o   = 1'b1;
                mem_port_o  = r_grant;
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_rx_ingress_arbiter.sv
// ============================================================================
// Module   : tb_rx_ingress_arbiter
// Brief    : Directed scenario bench for rx_ingress_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rx_ingress_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
        logic          err;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
        logic          err;
        logic [1:0]    port;
        int            cyc;
    } obeat_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NP-1:0]          rx_valid, rx_sof, rx_eof, rx_err, rx_ready, drop;
    logic [NP-1:0][DW-1:0]  rx_data;
    logic                   mem_valid, mem_sof, mem_eof, mem_err, mem_ready;
    logic [DW-1:0]          mem_data;
    logic [1:0]             mem_port;

    always #5 clk = ~clk;

    rx_ingress_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_WIDTH    (DW),
        .STALL_TIMEOUT (TO)
    ) dut (
        .switch_clk   (clk),
        .switch_rst_n (rst_n),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_sof_i     (rx_sof),
        .rx_eof_i     (rx_eof),
        .rx_err_i     (rx_err),
        .rx_ready_o   (rx_ready),
        .mem_valid_o  (mem_valid),
        .mem_sof_o    (mem_sof),
        .mem_eof_o    (mem_eof),
        .mem_err_o    (mem_err),
        .mem_data_o   (mem_data),
        .mem_port_o   (mem_port),
        .mem_ready_i  (mem_ready),
        .drop_o       (drop)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     valid_cnt;
    int     first_valid_cyc;
    int     drop_cnt [NP];
    bit     rdy_toggle = 1'b0;
    beat_t  src_q [NP][$];
    obeat_t out_q [$];

    task automatic clear_mon();
        out_q.delete();
        valid_cnt       = 0;
        first_valid_cyc = -1;
        for (int p = 0; p < NP; p++) drop_cnt[p] = 0;
    endtask

    task automatic push_beats(input int p, input int len, input int base, input bit sof_first, input bit eof_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d   = DW'(base + i);
            b.sof = sof_first && (i == 0);
            b.eof = eof_last && (i == len - 1);
            b.err = 1'b0;
            src_q[p].push_back(b);
        end
    endtask

    // One clock: drive queue fronts after the edge, observe at the falling edge.
    task automatic cycle();
        obeat_t o;
        @(posedge clk);
        #1;
        mem_ready = rdy_toggle ? ~mem_ready : 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                rx_valid[p] = 1'b1;
                rx_data[p]  = src_q[p][0].d;
                rx_sof[p]   = src_q[p][0].sof;
                rx_eof[p]   = src_q[p][0].eof;
                rx_err[p]   = src_q[p][0].err;
            end else begin
                rx_valid[p] = 1'b0;
                rx_data[p]  = '0;
                rx_sof[p]   = 1'b0;
                rx_eof[p]   = 1'b0;
                rx_err[p]   = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
        if (mem_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (mem_valid && mem_ready) begin
            o.d = mem_data; o.sof = mem_sof; o.eof = mem_eof; o.err = mem_err;
            o.port = mem_port; o.cyc = cyc;
            out_q.push_back(o);
        end
        for (int p = 0; p < NP; p++) begin
            drop_cnt[p] += int'(drop[p]);
            if (rx_valid[p] && rx_ready[p]) void'(src_q[p].pop_front());
        end
    endtask

    task automatic run_until_empty(input int budget, input string tag);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL %s_timeout: sources not drained after %0d cycles (required drained)", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        rx_valid  = '1;
        rx_sof    = '0;
        rx_eof    = '0;
        rx_err    = '1;
        rx_data   = '1;
        #12;
        n_checks++;
        if ({mem_valid, mem_sof, mem_eof, mem_err} !== 4'b0) $display("FAIL reset_mem_flags: got %b required 0000", {mem_valid, mem_sof, mem_eof, mem_err});
        else n_pass++;
        n_checks++;
        if ({mem_data, mem_port} !== 10'h0) $display("FAIL reset_mem_data: got %h required 000", {mem_data, mem_port});
        else n_pass++;
        n_checks++;
        if (rx_ready !== 4'b0) $display("FAIL reset_ready: got %b required 0000", rx_ready);
        else n_pass++;
        n_checks++;
        if (drop !== 4'b0) $display("FAIL reset_drop: got %b required 0000", drop);
        else n_pass++;
        rx_valid = '0; rx_err = '0; rx_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_ports();
        int sz;
        clear_mon();
        for (int p = 0; p < NP; p++) push_beats(p, 3, p * 16, 1'b1, 1'b1);
        run_until_empty(100, "all_ports");
        cycle();
        sz = out_q.size();
        n_checks++;
        if (sz !== 12) $display("FAIL all_ports_count: got %0d beats required 12", sz);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            if (k < sz) begin
                n_checks++;
                if ({out_q[k].port, out_q[k].d, out_q[k].sof, out_q[k].eof, out_q[k].err} !==
                    {2'(k / 3), 8'((k / 3) * 16 + k % 3), (k % 3) == 0, (k % 3) == 2, 1'b0})
                    $display("FAIL all_ports_beat%0d: got port=%0d data=%h sof=%b eof=%b err=%b required port=%0d data=%h",
                             k, out_q[k].port, out_q[k].d, out_q[k].sof, out_q[k].eof, out_q[k].err, k / 3, (k / 3) * 16 + k % 3);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int start, bad, sz;
        clear_mon();
        rdy_toggle = 1'b1;
        start = cyc + 1;
        push_beats(2, 60, 8'h40, 1'b1, 1'b1);
        run_until_empty(400, "backpressure");
        rdy_toggle = 1'b0;
        cycle();
        sz = out_q.size();
        n_checks++;
        if (sz !== 60) $display("FAIL bp_count: got %0d beats required 60", sz);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < sz; k++)
            if (out_q[k].d !== 8'(8'h40 + k) || out_q[k].port !== 2'd2 || out_q[k].err !== 1'b0) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL bp_payload: got %0d bad beats required 0", bad);
        else n_pass++;
        n_checks++;
        if (first_valid_cyc !== start + 1) $display("FAIL bp_latency: first valid at cycle %0d required %0d", first_valid_cyc, start + 1);
        else n_pass++;
        if (sz == 60) begin
            n_checks++;
            if ({out_q[0].sof, out_q[0].eof, out_q[59].sof, out_q[59].eof} !== 4'b1001)
                $display("FAIL bp_framing: got %b required 1001", {out_q[0].sof, out_q[0].eof, out_q[59].sof, out_q[59].eof});
            else n_pass++;
        end
    endtask

    task automatic test_stall_abort();
        int n, vc, nout;
        clear_mon();
        push_beats(1, 10, 8'h10, 1'b1, 1'b0);
        run_until_empty(50, "stall");
        n = 0;
        while (out_q.size() < 11 && n < 150) begin
            cycle();
            n++;
        end
        n_checks++;
        if (out_q.size() !== 11) $display("FAIL abort_count: got %0d beats required 11", out_q.size());
        else n_pass++;
        if (out_q.size() == 11) begin
            n_checks++;
            if ({out_q[10].port, out_q[10].d, out_q[10].sof, out_q[10].eof, out_q[10].err} !== {2'd1, 8'h00, 1'b0, 1'b1, 1'b1})
                $display("FAIL abort_beat: got port=%0d data=%h sof=%b eof=%b err=%b required port=1 data=00 sof=0 eof=1 err=1",
                         out_q[10].port, out_q[10].d, out_q[10].sof, out_q[10].eof, out_q[10].err);
            else n_pass++;
            n_checks++;
            if (out_q[10].cyc - out_q[9].cyc !== TO + 1)
                $display("FAIL abort_timing: got gap %0d required %0d", out_q[10].cyc - out_q[9].cyc, TO + 1);
            else n_pass++;
        end
        vc   = valid_cnt;
        nout = out_q.size();
        push_beats(1, 50, 8'h20, 1'b0, 1'b1);
        run_until_empty(100, "trailing");
        cycle();
        n_checks++;
        if (drop_cnt[1] !== 50) $display("FAIL trailing_drops: got %0d required 50", drop_cnt[1]);
        else n_pass++;
        n_checks++;
        if (valid_cnt !== vc || out_q.size() !== nout) $display("FAIL trailing_no_mem: got %0d valid cycles required 0", valid_cnt - vc);
        else n_pass++;
    endtask

    task automatic test_orphan();
        clear_mon();
        push_beats(3, 5, 8'h30, 1'b0, 1'b0);
        run_until_empty(20, "orphan");
        cycle();
        n_checks++;
        if (drop_cnt[3] !== 5) $display("FAIL orphan_drops: got %0d required 5", drop_cnt[3]);
        else n_pass++;
        n_checks++;
        if (valid_cnt !== 0 || drop_cnt[0] + drop_cnt[1] + drop_cnt[2] !== 0)
            $display("FAIL orphan_side: got valid=%0d other_drops=%0d required 0 0", valid_cnt, drop_cnt[0] + drop_cnt[1] + drop_cnt[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [10] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h10, 8'h11, 8'h90, 8'h91, 8'h20, 8'h21};
        logic [1:0] exp_p [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        int sz;
        clear_mon();
        push_beats(0, 2, 8'h00, 1'b1, 1'b1);
        push_beats(0, 2, 8'h10, 1'b1, 1'b1);
        push_beats(0, 2, 8'h20, 1'b1, 1'b1);
        push_beats(1, 2, 8'h80, 1'b1, 1'b1);
        push_beats(1, 2, 8'h90, 1'b1, 1'b1);
        run_until_empty(100, "b2b");
        cycle();
        sz = out_q.size();
        n_checks++;
        if (sz !== 10) $display("FAIL b2b_count: got %0d beats required 10", sz);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (k < sz) begin
                n_checks++;
                if (out_q[k].d !== exp_d[k] || out_q[k].port !== exp_p[k])
                    $display("FAIL b2b_beat%0d: got port=%0d data=%h required port=%0d data=%h",
                             k, out_q[k].port, out_q[k].d, exp_p[k], exp_d[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        int sz, errs;
        clear_mon();
        push_beats(0, 8, 8'h50, 1'b1, 1'b1);
        repeat (4) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_valid, mem_sof, mem_eof, mem_err, mem_data, mem_port} !== 14'h0)
            $display("FAIL midreset_outputs: got valid=%b data=%h port=%0d required all 0", mem_valid, mem_data, mem_port);
        else n_pass++;
        n_checks++;
        if ({rx_ready, drop} !== 8'h0) $display("FAIL midreset_ready_drop: got %b required 00000000", {rx_ready, drop});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL midreset_hold: got mem_valid=%b required 0", mem_valid);
        else n_pass++;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        push_beats(1, 2, 8'hA0, 1'b1, 1'b1);
        push_beats(0, 2, 8'hB0, 1'b1, 1'b1);
        run_until_empty(50, "postreset");
        cycle();
        sz = out_q.size();
        n_checks++;
        if (sz !== 4) $display("FAIL postreset_count: got %0d beats required 4", sz);
        else n_pass++;
        if (sz == 4) begin
            n_checks++;
            if ({out_q[0].port, out_q[0].d, out_q[1].d, out_q[2].port, out_q[2].d, out_q[3].d} !==
                {2'd0, 8'hB0, 8'hB1, 2'd1, 8'hA0, 8'hA1})
                $display("FAIL postreset_order: got first port=%0d data=%h required port=0 data=b0", out_q[0].port, out_q[0].d);
            else n_pass++;
        end
        errs = 0;
        for (int k = 0; k < sz; k++) errs += int'(out_q[k].err);
        n_checks++;
        if (errs !== 0) $display("FAIL postreset_no_err: got %0d error beats required 0", errs);
        else n_pass++;
    endtask

    initial begin
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_err = '0; rx_data = '0;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        clear_mon();
        test_reset();
        test_all_ports();
        test_backpressure();
        test_stall_abort();
        test_orphan();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
